// File: rtl/krnl_aes_pkg.sv
// rtl/krnl_aes_pkg.sv - shared register map, control bits and FSM types for krnl_aes
package krnl_aes_pkg;

  localparam logic [11:0] ADDR_CTRL    = 12'h000;
  localparam logic [11:0] ADDR_MODE    = 12'h010;
  localparam logic [11:0] ADDR_KEY_LEN = 12'h018;
  localparam logic [11:0] ADDR_STATUS  = 12'h020;
  localparam logic [11:0] ADDR_KEY_W7  = 12'h028;
  localparam logic [11:0] ADDR_KEY_W6  = 12'h030;
  localparam logic [11:0] ADDR_KEY_W5  = 12'h038;
  localparam logic [11:0] ADDR_KEY_W4  = 12'h040;
  localparam logic [11:0] ADDR_KEY_W3  = 12'h048;
  localparam logic [11:0] ADDR_KEY_W2  = 12'h050;
  localparam logic [11:0] ADDR_KEY_W1  = 12'h058;
  localparam logic [11:0] ADDR_KEY_W0  = 12'h060;

  localparam int CTRL_START = 0;
  localparam int CTRL_DONE  = 1;
  localparam int CTRL_IDLE  = 2;

  typedef enum logic [1:0] {
    KEY_128 = 2'd0,
    KEY_192 = 2'd1,
    KEY_256 = 2'd2
  } key_len_e;

  typedef enum logic [1:0] {WRRESET, WRIDLE, WRDATA, WRRESP} wr_state_e;
  typedef enum logic [1:0] {RDRESET, RDIDLE, RDDATA} rd_state_e;

  // Key words descend in address: KEY_W0 is the highest slot.
  function automatic logic [11:0] key_addr(input int unsigned n);
    return ADDR_KEY_W0 - 12'(8 * n);
  endfunction

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++)
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/krnl_aes_axi_ctrl_slv.sv
// rtl/krnl_aes_axi_ctrl_slv.sv - AXI4-Lite control slave holding mode, key length and AES key
module krnl_aes_axi_ctrl_slv
  import krnl_aes_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              s_axi_control_awvalid,
  output logic              s_axi_control_awready,
  input  logic [ADDR_W-1:0] s_axi_control_awaddr,
  input  logic              s_axi_control_wvalid,
  output logic              s_axi_control_wready,
  input  logic [DATA_W-1:0] s_axi_control_wdata,
  input  logic [3:0]        s_axi_control_wstrb,
  output logic              s_axi_control_bvalid,
  input  logic              s_axi_control_bready,
  output logic [1:0]        s_axi_control_bresp,
  input  logic              s_axi_control_arvalid,
  output logic              s_axi_control_arready,
  input  logic [ADDR_W-1:0] s_axi_control_araddr,
  output logic              s_axi_control_rvalid,
  input  logic              s_axi_control_rready,
  output logic [DATA_W-1:0] s_axi_control_rdata,
  output logic [1:0]        s_axi_control_rresp,
  output logic              key_exp_start,
  input  logic              key_exp_done,
  output logic              mode,
  output logic [1:0]        key_len,
  output logic [255:0]      aes_key,
  input  logic [3:0]        engine_busy
);

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  wr_state_e         wstate_q, wstate_nxt;
  rd_state_e         rstate_q, rstate_nxt;
  logic              init_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [ADDR_W-1:0] raddr;
  logic              aw_hs, w_hs, ar_hs, start_req, ctrl_rd;
  logic              busy_q, done_q, mode_q;
  logic [1:0]        key_len_q;
  logic [31:0]       key_q [8];
  logic [DATA_W-1:0] rd_mux, rdata_q;

  assign aw_hs = (wstate_q == WRIDLE) && s_axi_control_awvalid;
  assign w_hs  = (wstate_q == WRDATA) && s_axi_control_wvalid;
  assign ar_hs = (rstate_q == RDIDLE) && s_axi_control_arvalid;
  assign raddr = s_axi_control_araddr & WORD_MASK;

  assign s_axi_control_awready = (wstate_q == WRIDLE);
  assign s_axi_control_wready  = (wstate_q == WRDATA);
  assign s_axi_control_bvalid  = (wstate_q == WRRESP);
  assign s_axi_control_bresp   = 2'b00;
  assign s_axi_control_arready = (rstate_q == RDIDLE);
  assign s_axi_control_rvalid  = (rstate_q == RDDATA);
  assign s_axi_control_rresp   = 2'b00;
  assign s_axi_control_rdata   = rdata_q;

  assign mode    = mode_q;
  assign key_len = key_len_q;
  assign aes_key = {key_q[7], key_q[6], key_q[5], key_q[4],
                    key_q[3], key_q[2], key_q[1], key_q[0]};

  // init_q holds both FSMs in their RESET state for one full cycle after release.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      init_q   <= 1'b0;
      wstate_q <= WRRESET;
      rstate_q <= RDRESET;
      waddr_q  <= '0;
    end else begin
      init_q   <= 1'b1;
      wstate_q <= wstate_nxt;
      rstate_q <= rstate_nxt;
      if (aw_hs) waddr_q <= s_axi_control_awaddr & WORD_MASK;
    end
  end

  always_comb begin
    wstate_nxt = wstate_q;
    case (wstate_q)
      WRRESET: if (init_q) wstate_nxt = WRIDLE;
      WRIDLE:  if (s_axi_control_awvalid) wstate_nxt = WRDATA;
      WRDATA:  if (s_axi_control_wvalid) wstate_nxt = WRRESP;
      WRRESP:  if (s_axi_control_bready) wstate_nxt = WRIDLE;
      default: wstate_nxt = WRRESET;
    endcase
  end

  always_comb begin
    rstate_nxt = rstate_q;
    case (rstate_q)
      RDRESET: if (init_q) rstate_nxt = RDIDLE;
      RDIDLE:  if (s_axi_control_arvalid) rstate_nxt = RDDATA;
      RDDATA:  if (s_axi_control_rready) rstate_nxt = RDIDLE;
      default: rstate_nxt = RDRESET;
    endcase
  end

  assign start_req = w_hs && (waddr_q == ADDR_W'(ADDR_CTRL)) && s_axi_control_wstrb[0]
                     && s_axi_control_wdata[CTRL_START] && !busy_q;
  assign ctrl_rd   = ar_hs && (raddr == ADDR_W'(ADDR_CTRL));

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      key_exp_start <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mode_q        <= 1'b0;
      key_len_q     <= 2'd0;
      for (int n = 0; n < 8; n++) key_q[n] <= '0;
    end else begin
      key_exp_start <= start_req;
      if (start_req)         busy_q <= 1'b1;
      else if (key_exp_done) busy_q <= 1'b0;
      // A done pulse beats both the start clear and clear-on-read.
      if (key_exp_done)                done_q <= 1'b1;
      else if (start_req || ctrl_rd)   done_q <= 1'b0;
      if (w_hs && !busy_q) begin
        if (waddr_q == ADDR_W'(ADDR_MODE) && s_axi_control_wstrb[0])
          mode_q <= s_axi_control_wdata[0];
        if (waddr_q == ADDR_W'(ADDR_KEY_LEN) && s_axi_control_wstrb[0])
          key_len_q <= s_axi_control_wdata[1:0];
        for (int unsigned n = 0; n < 8; n++)
          if (waddr_q == ADDR_W'(key_addr(n)))
            key_q[n] <= apply_strb(key_q[n], s_axi_control_wdata, s_axi_control_wstrb);
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (raddr == ADDR_W'(ADDR_CTRL)) begin
      rd_mux[CTRL_START] = busy_q;
      rd_mux[CTRL_DONE]  = done_q;
      rd_mux[CTRL_IDLE]  = !busy_q;
    end
    if (raddr == ADDR_W'(ADDR_MODE))    rd_mux[0]   = mode_q;
    if (raddr == ADDR_W'(ADDR_KEY_LEN)) rd_mux[1:0] = key_len_q;
    if (raddr == ADDR_W'(ADDR_STATUS))  rd_mux[3:0] = engine_busy;
    for (int unsigned n = 0; n < 8; n++)
      if (raddr == ADDR_W'(key_addr(n))) rd_mux = key_q[n];
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)  rdata_q <= '0;
    else if (ar_hs) rdata_q <= rd_mux;
  end

endmodule

// File: tb/tb_krnl_aes_axi_ctrl_slv.sv
// tb/tb_krnl_aes_axi_ctrl_slv.sv - directed self-checking bench for krnl_aes_axi_ctrl_slv
module tb_krnl_aes_axi_ctrl_slv;

  logic         ap_clk = 1'b0;
  logic         ap_rst_n = 1'b0;
  logic         awvalid = 1'b0, awready;
  logic [11:0]  awaddr = '0;
  logic         wvalid = 1'b0, wready;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         bvalid, bready = 1'b0;
  logic [1:0]   bresp;
  logic         arvalid = 1'b0, arready;
  logic [11:0]  araddr = '0;
  logic         rvalid, rready = 1'b0;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         key_exp_start;
  logic         key_exp_done = 1'b0;
  logic         mode;
  logic [1:0]   key_len;
  logic [255:0] aes_key;
  logic [3:0]   engine_busy = '0;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;

  krnl_aes_axi_ctrl_slv dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_axi_control_awvalid(awvalid), .s_axi_control_awready(awready),
    .s_axi_control_awaddr(awaddr),
    .s_axi_control_wvalid(wvalid), .s_axi_control_wready(wready),
    .s_axi_control_wdata(wdata), .s_axi_control_wstrb(wstrb),
    .s_axi_control_bvalid(bvalid), .s_axi_control_bready(bready),
    .s_axi_control_bresp(bresp),
    .s_axi_control_arvalid(arvalid), .s_axi_control_arready(arready),
    .s_axi_control_araddr(araddr),
    .s_axi_control_rvalid(rvalid), .s_axi_control_rready(rready),
    .s_axi_control_rdata(rdata), .s_axi_control_rresp(rresp),
    .key_exp_start(key_exp_start), .key_exp_done(key_exp_done),
    .mode(mode), .key_len(key_len), .aes_key(aes_key),
    .engine_busy(engine_busy)
  );

  always #5 ap_clk = ~ap_clk;

  always @(negedge ap_clk) if (key_exp_start) start_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge ap_clk);
    #1;
  endtask

  task automatic aw_phase(input logic [11:0] a);
    bit ok = 0;
    awaddr = a; awvalid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin ok = awready; tick(1); end
    awvalid = 1'b0;
    check("aw_handshake", ok, 1);
  endtask

  task automatic w_phase(input logic [31:0] d, input logic [3:0] s);
    bit ok = 0;
    wdata = d; wstrb = s; wvalid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin ok = wready; tick(1); end
    wvalid = 1'b0;
    check("w_handshake", ok, 1);
  endtask

  task automatic b_phase(output logic [1:0] resp);
    bit ok = 0;
    resp = 2'bxx;
    bready = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin ok = bvalid; resp = bresp; tick(1); end
    bready = 1'b0;
    check("b_handshake", ok, 1);
  endtask

  task automatic ar_phase(input logic [11:0] a);
    bit ok = 0;
    araddr = a; arvalid = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin ok = arready; tick(1); end
    arvalid = 1'b0;
    check("ar_handshake", ok, 1);
  endtask

  task automatic r_phase(output logic [31:0] d, output logic [1:0] resp);
    bit ok = 0;
    d = 'x; resp = 2'bxx;
    rready = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin ok = rvalid; d = rdata; resp = rresp; tick(1); end
    rready = 1'b0;
    check("r_handshake", ok, 1);
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [1:0] resp;
    aw_phase(a);
    w_phase(d, s);
    b_phase(resp);
    check($sformatf("bresp_%03h", a), resp, 2'b00);
  endtask

  task automatic read_expect(input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  resp;
    ar_phase(a);
    r_phase(d, resp);
    check($sformatf("rdata_%03h", a), d, exp);
    check($sformatf("rresp_%03h", a), resp, 2'b00);
  endtask

  initial begin
    logic [31:0]  kw [8];
    logic [255:0] exp_key;
    logic [31:0]  d;
    logic [1:0]   resp;
    int           s0;
    bit           bad;

    // Reset values while held in reset
    tick(3);
    check("rst_awready", awready, 0);
    check("rst_arready", arready, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_key_exp_start", key_exp_start, 0);
    check("rst_rdata", rdata, 0);
    check("rst_aes_key", aes_key, 0);

    // One cycle in RESET after release, ready on the second edge
    ap_rst_n = 1'b1;
    tick(1);
    check("init_awready_edge1", awready, 0);
    check("init_arready_edge1", arready, 0);
    tick(1);
    check("init_awready_edge2", awready, 1);
    check("init_arready_edge2", arready, 1);

    // Post-reset sweep
    for (int a = 0; a <= 'h060; a += 8)
      read_expect(12'(a), (a == 0) ? 32'h4 : 32'h0);

    // All-ones write and readback, plus unmapped addresses
    for (int a = 'h010; a <= 'h060; a += 8) axi_write(12'(a), 32'hFFFF_FFFF, 4'hF);
    axi_write(12'h008, 32'hFFFF_FFFF, 4'hF);
    axi_write(12'h064, 32'hFFFF_FFFF, 4'hF);
    read_expect(12'h010, 32'h1);
    read_expect(12'h018, 32'h3);
    read_expect(12'h020, 32'h0);
    for (int a = 'h028; a <= 'h060; a += 8) read_expect(12'(a), 32'hFFFF_FFFF);
    read_expect(12'h008, 32'h0);
    read_expect(12'h064, 32'h0);
    read_expect(12'h013, 32'h1);

    // Byte strobes on key words
    axi_write(12'h060, 32'h1234_5678, 4'b0101);
    read_expect(12'h060, 32'hFF34_FF78);
    axi_write(12'h028, 32'h00AA_BBCC, 4'b1000);
    read_expect(12'h028, 32'h00FF_FFFF);

    // Key length and full key
    axi_write(12'h018, 32'h2, 4'hF);
    for (int n = 7; n >= 0; n--) begin
      kw[n] = 32'h1111_1111 * (n + 1);
      axi_write(12'h060 - 12'(8 * n), kw[n], 4'hF);
    end
    exp_key = {kw[7], kw[6], kw[5], kw[4], kw[3], kw[2], kw[1], kw[0]};
    check("aes_key", aes_key, exp_key);
    check("key_len_out", key_len, 2'd2);
    check("mode_out", mode, 1'b1);

    // Start key expansion
    engine_busy = 4'hA;
    s0 = start_cnt;
    axi_write(12'h000, 32'h1, 4'hF);
    tick(3);
    check("start_pulse_count", start_cnt - s0, 1);
    read_expect(12'h000, 32'h1);
    read_expect(12'h020, 32'hA);

    // Writes while busy are acknowledged but have no effect
    axi_write(12'h000, 32'h1, 4'hF);
    axi_write(12'h010, 32'h0, 4'hF);
    axi_write(12'h018, 32'h0, 4'hF);
    axi_write(12'h038, 32'h0, 4'hF);
    tick(3);
    check("busy_no_restart", start_cnt - s0, 1);
    read_expect(12'h010, 32'h1);
    read_expect(12'h018, 32'h2);
    check("busy_mode_out", mode, 1'b1);
    check("busy_aes_key", aes_key, exp_key);

    // Write response back-pressure
    aw_phase(12'h010);
    w_phase(32'h0, 4'hF);
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      if (!bvalid || awready || bresp !== 2'b00) bad = 1;
      tick(1);
    end
    check("b_stall_stable", bad, 0);
    b_phase(resp);
    check("b_stall_bresp", resp, 2'b00);

    // Read response back-pressure
    ar_phase(12'h010);
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      if (!rvalid || arready || rdata !== 32'h1) bad = 1;
      tick(1);
    end
    check("r_stall_stable", bad, 0);
    r_phase(d, resp);
    check("r_stall_rdata", d, 32'h1);

    // Completion and clear-on-read
    tick(20);
    key_exp_done = 1'b1;
    tick(1);
    key_exp_done = 1'b0;
    read_expect(12'h000, 32'h6);
    read_expect(12'h000, 32'h4);

    // Done arriving on the same edge as a CTRL read
    axi_write(12'h000, 32'h1, 4'hF);
    tick(2);
    check("restart_pulse_count", start_cnt - s0, 2);
    check("coincide_arready", arready, 1);
    araddr = 12'h000; arvalid = 1'b1; key_exp_done = 1'b1;
    tick(1);
    arvalid = 1'b0; key_exp_done = 1'b0;
    r_phase(d, resp);
    check("coincide_rdata", d, 32'h1);
    read_expect(12'h000, 32'h6);
    read_expect(12'h000, 32'h4);

    // Asynchronous reset in WRDATA
    aw_phase(12'h010);
    check("mid_wready", wready, 1);
    ap_rst_n = 1'b0;
    #1;
    check("mid_rst_wready", wready, 0);
    check("mid_rst_bvalid", bvalid, 0);
    check("mid_rst_mode", mode, 0);
    check("mid_rst_aes_key", aes_key, 0);
    tick(2);
    ap_rst_n = 1'b1;
    tick(3);
    read_expect(12'h010, 32'h0);
    read_expect(12'h018, 32'h0);
    read_expect(12'h028, 32'h0);
    read_expect(12'h000, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
